// File: rtl/ram_1r1w_sync_be.sv
// ram_1r1w_sync_be: 1R1W byte-enable RAM with registered valid/ready read port and post-reset clear sweep
module ram_1r1w_sync_be #(
  parameter int width_p = 32,
  parameter int depth_p = 16,
  parameter bit bypass_p = 1'b1,
  parameter logic [width_p-1:0] init_value_p = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       init_done_o,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [$clog2(depth_p)-1:0] wr_addr_i,
  input  logic [width_p-1:0]         wr_data_i,
  input  logic [width_p/8-1:0]       wr_be_i,
  input  logic                       rd_valid_i,
  output logic                       rd_ready_o,
  input  logic [$clog2(depth_p)-1:0] rd_addr_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [width_p-1:0]         rd_data_o
);
  localparam int addr_w = $clog2(depth_p);
  localparam int bytes = width_p / 8;
  typedef enum logic {CLEAR, READY} state_e;
  state_e state;
  logic [addr_w-1:0] clr_cnt;
  logic [width_p-1:0] mem [depth_p];
  logic wr_acc, rd_acc, wr_in, rd_in, hit;
  logic [width_p-1:0] old_data, rd_next;
  assign init_done_o = state == READY;
  assign wr_ready_o = init_done_o;
  assign rd_ready_o = init_done_o & (!rd_valid_o | rd_ready_i);
  assign wr_acc = wr_valid_i & wr_ready_o;
  assign rd_acc = rd_valid_i & rd_ready_o;
  // Range checks only exist when the depth leaves unused address codes
  if (depth_p == (1 << addr_w)) begin : g_pow2
    assign wr_in = 1'b1;
    assign rd_in = 1'b1;
  end else begin : g_npow2
    assign wr_in = wr_addr_i < addr_w'(depth_p);
    assign rd_in = rd_addr_i < addr_w'(depth_p);
  end
  assign hit = bypass_p && wr_acc && wr_in && wr_addr_i == rd_addr_i;
  always_comb begin
    old_data = rd_in ? mem[rd_addr_i] : '0;
    rd_next = old_data;
    for (int k = 0; k < bytes; k++)
      rd_next[8*k +: 8] = hit && wr_be_i[k] ? wr_data_i[8*k +: 8] : old_data[8*k +: 8];
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= CLEAR;
      clr_cnt <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o <= '0;
    end else begin
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == addr_w'(depth_p - 1)) state <= READY;
      end
      if (rd_acc) begin
        rd_valid_o <= 1'b1;
        rd_data_o <= rd_next;
      end else if (rd_ready_i) begin
        rd_valid_o <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (state == CLEAR && reset_n_i) mem[clr_cnt] <= init_value_p;
    else if (wr_acc && wr_in)
      for (int k = 0; k < bytes; k++)
        if (wr_be_i[k]) mem[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
  end
endmodule

// File: tb/tb_ram_1r1w_sync_be.sv
// tb_ram_1r1w_sync_be: directed checks of write-first and read-old instances driven in lockstep
module tb_ram_1r1w_sync_be;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_valid = 1'b0, rd_valid = 1'b0, rd_ready = 1'b1;
  logic [3:0] wr_addr = '0, rd_addr = '0, wr_be = '0;
  logic [31:0] wr_data = '0;
  logic done_1, wrdy_1, rrdy_1, rv_1, done_0, wrdy_0, rrdy_0, rv_0;
  logic [31:0] rd_1, rd_0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  ram_1r1w_sync_be #(.width_p(32), .depth_p(16), .bypass_p(1'b1), .init_value_p(32'hA5A5A5A5)) u1 (
    .clk_i(clk), .reset_n_i(reset_n), .init_done_o(done_1),
    .wr_valid_i(wr_valid), .wr_ready_o(wrdy_1), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_valid_i(rd_valid), .rd_ready_o(rrdy_1), .rd_addr_i(rd_addr),
    .rd_valid_o(rv_1), .rd_ready_i(rd_ready), .rd_data_o(rd_1));
  ram_1r1w_sync_be #(.width_p(32), .depth_p(16), .bypass_p(1'b0), .init_value_p(32'hA5A5A5A5)) u0 (
    .clk_i(clk), .reset_n_i(reset_n), .init_done_o(done_0),
    .wr_valid_i(wr_valid), .wr_ready_o(wrdy_0), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_valid_i(rd_valid), .rd_ready_o(rrdy_0), .rd_addr_i(rd_addr),
    .rd_valid_o(rv_0), .rd_ready_i(rd_ready), .rd_data_o(rd_0));
  typedef struct {
    logic wv; logic [3:0] wa; logic [31:0] wd; logic [3:0] be;
    logic rv; logic [3:0] ra;
    logic ev; logic [31:0] e1; logic [31:0] e0;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic wv, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be,
                       input logic rv, input logic [3:0] ra, input logic rr);
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_valid = rv; rd_addr = ra; rd_ready = rr;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, " done"}, {31'b0, done_1 | done_0}, 32'd0);
    chk({tag, " wr_ready"}, {31'b0, wrdy_1 | wrdy_0}, 32'd0);
    chk({tag, " rd_ready"}, {31'b0, rrdy_1 | rrdy_0}, 32'd0);
    chk({tag, " rd_valid"}, {31'b0, rv_1 | rv_0}, 32'd0);
    chk({tag, " rd_data"}, rd_1 | rd_0, 32'd0);
  endtask
  task automatic clear_sweep(input string tag);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) begin
        chk($sformatf("%s done@%0d", tag, i), {30'b0, done_1, done_0}, 32'd0);
        chk($sformatf("%s rdy@%0d", tag, i), {28'b0, wrdy_1, wrdy_0, rrdy_1, rrdy_0}, 32'd0);
      end else begin
        chk($sformatf("%s done@16", tag), {30'b0, done_1, done_0}, 32'd3);
        chk($sformatf("%s rdy@16", tag), {28'b0, wrdy_1, wrdy_0, rrdy_1, rrdy_0}, 32'hF);
      end
    end
  endtask
  initial begin
    vecs[0] = '{1'b1, 4'd3, 32'h11223344, 4'hF, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 4'd3, 32'hAABBCCDD, 4'h5, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
    vecs[3] = '{1'b1, 4'd5, 32'h00000000, 4'hF, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 4'd5, 32'hDEADBEEF, 4'hC, 1'b1, 4'd5, 1'b1, 32'hDEAD0000, 32'h00000000};
    vecs[5] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, 1'b1, 32'hDEAD0000, 32'hDEAD0000};
    vecs[6] = '{1'b1, 4'd2, 32'h12345678, 4'hF, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 4'd2, 1'b1, 32'h12345678, 32'h12345678};
    vecs[8] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[9] = '{1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0};
    repeat (3) tick();
    check_reset_outputs("reset");
    clear_sweep("clear");
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b1);
      tick();
      chk($sformatf("init valid a%0d", i), {30'b0, rv_1, rv_0}, 32'd3);
      chk($sformatf("init data a%0d", i), rd_1 & rd_0, 32'hA5A5A5A5);
    end
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].rv, vecs[i].ra, 1'b1);
      tick();
      chk($sformatf("vec%0d valid1", i), {31'b0, rv_1}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d valid0", i), {31'b0, rv_0}, {31'b0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d data1", i), rd_1, vecs[i].e1);
        chk($sformatf("vec%0d data0", i), rd_0, vecs[i].e0);
      end
    end
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2, 1'b0);
    tick();
    chk("bp first data", rd_1, 32'h12345678);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp hold valid %0d", i), {30'b0, rv_1, rv_0}, 32'd3);
      chk($sformatf("bp hold data %0d", i), rd_1 & rd_0, 32'h12345678);
      chk($sformatf("bp rd_ready %0d", i), {30'b0, rrdy_1, rrdy_0}, 32'd0);
    end
    rd_ready = 1'b1;
    #1;
    chk("bp release rd_ready", {30'b0, rrdy_1, rrdy_0}, 32'd3);
    tick();
    chk("bp next valid", {30'b0, rv_1, rv_0}, 32'd3);
    chk("bp next data", rd_1 & rd_0, 32'hA5A5A5A5);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    chk("bp drain valid", {30'b0, rv_1, rv_0}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 32'hF0000000 | 32'(i * 32'h00010101), 4'hF, 1'b0, 4'd0, 1'b1);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b1);
      tick();
      chk($sformatf("stream valid %0d", i), {30'b0, rv_1, rv_0}, 32'd3);
      chk($sformatf("stream data1 %0d", i), rd_1, 32'hF0000000 | 32'(i * 32'h00010101));
      chk($sformatf("stream data0 %0d", i), rd_0, 32'hF0000000 | 32'(i * 32'h00010101));
    end
    drive(1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b0, 4'd0, 1'b1);
    tick();
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7, 1'b0);
    tick();
    chk("pre-reset data", rd_1 & rd_0, 32'hCAFEF00D);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_sweep("reclear");
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7, 1'b1);
    tick();
    chk("reclear valid", {30'b0, rv_1, rv_0}, 32'd3);
    chk("reclear a7 data1", rd_1, 32'hA5A5A5A5);
    chk("reclear a7 data0", rd_0, 32'hA5A5A5A5);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
